fifo_ctrl: RTL and testbench

//  Pointer/flag controller for a word FIFO built on an external storage array
//  (DEPTH x W register file, sync write, async read). It sequences pushes and

---
 rtl/fifo_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a DEPTH-entry word FIFO on external storage.
// Optional sticky overflow/underflow flags: define FIFO_CTRL_ERR_STICKY_EN.
module fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic          flush,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          err_ovf,
    output logic          err_udf
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0] count_reg, count_next;
    logic        full_reg, full_next;
    logic        empty_reg, empty_next;
    logic        push_ok, pop_ok;

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign pop_ok  = rd_req & ~flush & ~empty_reg;
    assign push_ok = wr_req & ~flush & (~full_reg | pop_ok);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok)
                wr_ptr_next = wr_ptr_reg + ONE;
            if (pop_ok)
                rd_ptr_next = rd_ptr_reg + ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + ONE;
                2'b01:   count_next = count_reg - ONE;
                default: count_next = count_reg;
            endcase
        end
        full_next  = (count_next == FULL_COUNT);
        empty_next = (count_next == '0);
    end

    // Flags are registered alongside the count so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
        end
    end

    assign wr_en   = push_ok;
    assign rd_en   = pop_ok;
    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];
    assign count   = count_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

`ifdef FIFO_CTRL_ERR_STICKY_EN
    logic err_ovf_reg;
    logic err_udf_reg;

    // Flush clears the flags even if a new error condition coincides.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ovf_reg <= 1'b0;
            err_udf_reg <= 1'b0;
        end else if (flush) begin
            err_ovf_reg <= 1'b0;
            err_udf_reg <= 1'b0;
        end else begin
            if (wr_req & full_reg & ~pop_ok)
                err_ovf_reg <= 1'b1;
            if (rd_req & empty_reg)
                err_udf_reg <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_udf = err_udf_reg;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, rd_req, flush;
    logic       wr_en, rd_en, full, empty, err_ovf, err_udf;
    logic [1:0] wr_addr, rd_addr;
    logic [2:0] count;

    typedef struct packed {
        logic       wen;
        logic       ren;
        logic [1:0] wa;
        logic [1:0] ra;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    fifo_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the outputs expected during that cycle.
    // ovf/udf are the sticky-build values; the default build expects them low.
    task automatic apply(input logic rst_n, input logic wr, input logic rd, input logic fl,
                         input logic wen, input logic ren, input int wa, input int ra,
                         input int cnt, input logic ovf, input logic udf);
        exp_t e;
        reset  = rst_n;
        wr_req = wr;
        rd_req = rd;
        flush  = fl;
        e.wen   = wen;
        e.ren   = ren;
        e.wa    = 2'(wa);
        e.ra    = 2'(ra);
        e.cnt   = 3'(cnt);
        e.full  = (cnt == 4);
        e.empty = (cnt == 0);
`ifdef FIFO_CTRL_ERR_STICKY_EN
        e.ovf = ovf;
        e.udf = udf;
`else
        e.ovf = 1'b0;
        e.udf = 1'b0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, g;
            e = exp_q.pop_front();
            g = '{wr_en, rd_en, wr_addr, rd_addr, count, full, empty, err_ovf, err_udf};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL txn%0d: got wen=%b ren=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b ovf=%b udf=%b, want wen=%b ren=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b ovf=%b udf=%b",
                         txn, g.wen, g.ren, g.wa, g.ra, g.cnt, g.full, g.empty, g.ovf, g.udf,
                         e.wen, e.ren, e.wa, e.ra, e.cnt, e.full, e.empty, e.ovf, e.udf);
            end else begin
                $display("txn%0d ok: wen=%b ren=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b ovf=%b udf=%b",
                         txn, g.wen, g.ren, g.wa, g.ra, g.cnt, g.full, g.empty, g.ovf, g.udf);
            end
            txn++;
        end
    end

    initial begin
        int wait_cycles;
        reset  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Two pushes, then reset low mid-cycle: state clears with no clock edge.
        apply(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill: addresses 0..3, then a rejected 5th push.
        apply(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        apply(1, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        apply(1, 1, 0, 0, 1, 0, 3, 0, 3, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);

        // Full with push and pop together: both accepted, count holds at 4.
        apply(1, 1, 1, 0, 1, 1, 0, 0, 4, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 1, 1, 4, 1, 0);

        // Drain to empty.
        apply(1, 0, 1, 0, 0, 1, 1, 1, 4, 1, 0);
        apply(1, 0, 1, 0, 0, 1, 1, 2, 3, 1, 0);
        apply(1, 0, 1, 0, 0, 1, 1, 3, 2, 1, 0);
        apply(1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0);

        // Empty with push and pop: push only.
        apply(1, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 2, 1, 1, 1, 1);

        // Six push/pop pairs at count 1: both pointers wrap.
        apply(1, 1, 1, 0, 1, 1, 2, 1, 1, 1, 1);
        apply(1, 1, 1, 0, 1, 1, 3, 2, 1, 1, 1);
        apply(1, 1, 1, 0, 1, 1, 0, 3, 1, 1, 1);
        apply(1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1);
        apply(1, 1, 1, 0, 1, 1, 2, 1, 1, 1, 1);
        apply(1, 1, 1, 0, 1, 1, 3, 2, 1, 1, 1);

        // Build count 3, then flush with a push request.
        apply(1, 1, 0, 0, 1, 0, 0, 3, 1, 1, 1);
        apply(1, 1, 0, 0, 1, 0, 1, 3, 2, 1, 1);
        apply(1, 1, 0, 1, 0, 0, 2, 3, 3, 1, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pop on empty: rejected; sticky underflow held until flush.
        apply(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
